cpu_bus_ctrl: RTL and testbench
===============================

// Module: cpu_bus_ctrl
// PURPOSE
//  Bus-cycle controller between the MCS8 T-state sequencer and a synchronous memory/IO port.
//  Latches address and cycle type at T1, runs a REQ/ACK transaction, and drives READY back to the sequencer.
//  Posts writes, holds one pending cycle, and aborts hung transactions with a timeout.
// PARAMETERS
//  ADDR_W   14   memory address width
//  DATA_W   8    data width
//  TMO_CYC  255  clocks without ACK before abort; 0 = timeout disabled
// PORTS
//  CLK_I        in   1       single clock; all logic on posedge
//  RST_I        in   1       asynchronous, active-high reset
//  STEP_I       in   1       1-clk pulse, sequencer advancing T-state (SYNC-qualified)
//  STATE_I      in   3       current T-state code (T1=010 T1I=110 T2=100 WAIT=000 T3=001 T4=111 T5=101 STOP=011)
//  CTYPE_I      in   2       cycle type, valid at T1: 00 PCI fetch, 10 PCR read, 01 PCC io, 11 PCW write
//  ADDR_I       in   ADDR_W  address from datapath, valid at T1
//  WDATA_I      in   DATA_W  write data, valid at T3
//  READY_O      out  1       to sequencer; sampled at T2/WAIT
//  RDATA_O      out  DATA_W  read data to datapath
//  RDATA_VLD_O  out  1       RDATA_O holds a completed read
//  ERR_O        out  1       1-clk pulse on timeout abort
//  MEM_REQ_O    out  1       request, held until ACK or abort
//  MEM_WE_O     out  1       1 = write (PCW)
//  MEM_IO_O     out  1       1 = IO space (PCC)
//  MEM_ADDR_O   out  ADDR_W  registered address
//  MEM_WDATA_O  out  DATA_W  registered write data
//  MEM_ACK_I    in   1       1-clk completion pulse; ignored unless MEM_REQ_O=1
//  MEM_RDATA_I  in   DATA_W  read data, valid with MEM_ACK_I
// BEHAVIOUR
//  Reset: FSM=IDLE, all outputs 0, PEND=0, timeout counter 0. Reset mid-transaction drops MEM_REQ_O immediately.
//  "T1 event" = STEP_I & STATE_I in {T1,T1I}; "T3 event" = STEP_I & STATE_I==T3.
//  IDLE (READY_O=0): on T1 event, latch ADDR_I->MEM_ADDR_O and CTYPE_I->WE/IO; go to WR_WAIT if PCW, else RD_REQ.
//  RD_REQ (MEM_REQ_O=1, READY_O=0): ACK -> RDATA_O<=MEM_RDATA_I, go to RD_DONE.
//    Timeout -> RDATA_O<=all-ones, ERR_O pulse, go to RD_DONE.
//  RD_DONE (READY_O=1, RDATA_VLD_O=1): T3 event -> IDLE; RDATA_O holds its value until the next read completes.
//  WR_WAIT (READY_O=1, posted write): T3 event -> MEM_WDATA_O<=WDATA_I, go to WR_REQ.
//  WR_REQ (MEM_REQ_O=1, MEM_WE_O=1, READY_O=0): ACK or timeout (with ERR_O) -> IDLE.
//    If PEND=1, go instead to the pending cycle's RD_REQ/WR_WAIT, loading its shadow address/type.
//  Pending slot: a T1 event in WR_REQ latches ADDR_I/CTYPE_I into shadow regs and sets PEND.
//    READY_O stays 0, so the sequencer waits in T2/WAIT. A T1 event in any non-IDLE state other than WR_REQ is a protocol error: ignored.
//  Latency: read with ACK k clocks after REQ -> READY_O high k+1 clocks after the T1 event. Write: READY_O high the clock after the T1 event.
//  Timeout: counter clears on each REQ rise and counts while MEM_REQ_O=1; abort when count==TMO_CYC-1.
//    ACK in the same clock as expiry wins (no ERR_O).
//  STATE_I==STOP: no new cycles start; an outstanding REQ still completes.
//  MEM_* and READY_O are registered outputs; there is no combinational path from any input to any output.
// STRUCTURE
//  cpu_pkg: T-state codes, cycle-type codes, bus-FSM state enum; shared with the T-state sequencer.
//  Sub-module cpu_bus_wdog: TMO_CYC counter with clr/run inputs and an expire pulse.
//    Its width is $clog2(TMO_CYC+1); TMO_CYC=0 makes expire constant 0.
//  Top level contains the FSM, address/type/shadow registers, and data registers.
// TESTING
//  Fetch PCI @0x0123, ACK after 3 clk with 0x3E -> REQ 3 clk, RDATA_O=0x3E, READY_O=1 until T3, IO=0 WE=0.
//  Write PCW @0x2000, data 0x55 at T3, ACK after 5 clk -> READY_O=1 at T2; MEM_WDATA_O=0x55, WE=1, returns IDLE.
//  Write held 20 clk while next T1 fetches @0x0124 -> PEND=1, READY_O=0 through WAIT; after ACK, REQ for 0x0124.
//  Read with no ACK, TMO_CYC=8 -> REQ drops after 8 clk, ERR_O one pulse, RDATA_O=0xFF, READY_O=1.
//  ACK arrives in the same clock as expiry -> data captured, ERR_O stays 0.
//  RST_I asserted mid-RD_REQ -> MEM_REQ_O=0 asynchronously; next T1 starts a clean cycle; PCC sets MEM_IO_O=1.

Source files
------------

// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the MCS8 T-state sequencer and the bus-cycle
// controller: T-state codes, cycle-type codes, bus FSM state enum, and
// small decode helpers used by both sides.
// ---------------------------------------------------------------------------
package cpu_pkg;

    // T-state codes as presented on STATE_I
    typedef enum logic [2:0] {
        TS_WAIT = 3'b000,
        TS_T3   = 3'b001,
        TS_T1   = 3'b010,
        TS_STOP = 3'b011,
        TS_T2   = 3'b100,
        TS_T5   = 3'b101,
        TS_T1I  = 3'b110,
        TS_T4   = 3'b111
    } tstate_e;

    // Cycle types presented on CTYPE_I at T1
    typedef enum logic [1:0] {
        CT_PCI = 2'b00,   // instruction fetch
        CT_PCC = 2'b01,   // IO cycle
        CT_PCR = 2'b10,   // memory read
        CT_PCW = 2'b11    // memory write
    } ctype_e;

    // Bus-cycle controller FSM states
    typedef enum logic [2:0] {
        BUS_IDLE    = 3'd0,
        BUS_RD_REQ  = 3'd1,
        BUS_RD_DONE = 3'd2,
        BUS_WR_WAIT = 3'd3,
        BUS_WR_REQ  = 3'd4
    } bus_state_e;

    function automatic logic is_t1_code(input logic [2:0] s);
        return (s == TS_T1) || (s == TS_T1I);
    endfunction

    function automatic logic ctype_is_write(input logic [1:0] c);
        return c == CT_PCW;
    endfunction

    function automatic logic ctype_is_io(input logic [1:0] c);
        return c == CT_PCC;
    endfunction

    // Writes are posted: they first wait for T3 to collect data.
    function automatic bus_state_e cycle_entry_state(input logic [1:0] c);
        return ctype_is_write(c) ? BUS_WR_WAIT : BUS_RD_REQ;
    endfunction

    function automatic logic is_req_state(input bus_state_e s);
        return (s == BUS_RD_REQ) || (s == BUS_WR_REQ);
    endfunction

endpackage

// File: rtl/cpu_bus_wdog.sv
// ---------------------------------------------------------------------------
// cpu_bus_wdog
// Transaction watchdog for the bus-cycle controller. Counts clocks while a
// request is outstanding and flags expiry when the count reaches TMO_CYC-1,
// so a request aborts after exactly TMO_CYC clocks. TMO_CYC=0 disables it.
//
// Ports
//   i_clk     in  1  clock, posedge
//   i_rst     in  1  asynchronous active-high reset
//   i_clr     in  1  restart count (new request about to be raised)
//   i_run     in  1  request currently outstanding
//   o_expire  out 1  request has been outstanding for TMO_CYC clocks
// ---------------------------------------------------------------------------
module cpu_bus_wdog #(
    parameter int TMO_CYC = 255
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_run,
    output logic o_expire
);

    localparam int CNT_W = (TMO_CYC > 0) ? $clog2(TMO_CYC + 1) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'((TMO_CYC > 0) ? TMO_CYC - 1 : 0);

    logic [CNT_W-1:0] r_cnt;
    logic             w_hit;

    assign w_hit    = (TMO_CYC != 0) && (r_cnt == LIMIT);
    assign o_expire = i_run & w_hit;

    // Counting stops at the limit; the controller leaves the request state
    // on expiry, so the count never wraps.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_run && !w_hit) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/cpu_bus_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_bus_ctrl
// Bus-cycle controller between the MCS8 T-state sequencer and a synchronous
// memory/IO port. Latches address and cycle type at T1, runs a REQ/ACK
// transaction, and drives READY back to the sequencer. Writes are posted,
// one further cycle can be held pending behind an outstanding write, and
// hung transactions are aborted by a watchdog.
//
// Ports
//   CLK_I        in   1       clock, posedge
//   RST_I        in   1       asynchronous active-high reset
//   STEP_I       in   1       sequencer advancing T-state (1-clk pulse)
//   STATE_I      in   3       current T-state code
//   CTYPE_I      in   2       cycle type, valid at T1
//   ADDR_I       in   ADDR_W  address, valid at T1
//   WDATA_I      in   DATA_W  write data, valid at T3
//   READY_O      out  1       ready to sequencer (T2/WAIT)
//   RDATA_O      out  DATA_W  read data to datapath
//   RDATA_VLD_O  out  1       RDATA_O holds a completed read
//   ERR_O        out  1       1-clk pulse on timeout abort
//   MEM_REQ_O    out  1       request, held until ACK or abort
//   MEM_WE_O     out  1       write cycle
//   MEM_IO_O     out  1       IO-space cycle
//   MEM_ADDR_O   out  ADDR_W  registered address
//   MEM_WDATA_O  out  DATA_W  registered write data
//   MEM_ACK_I    in   1       completion pulse, honoured only while REQ=1
//   MEM_RDATA_I  in   DATA_W  read data, valid with MEM_ACK_I
// ---------------------------------------------------------------------------
module cpu_bus_ctrl
    import cpu_pkg::*;
#(
    parameter int ADDR_W  = 14,
    parameter int DATA_W  = 8,
    parameter int TMO_CYC = 255
) (
    input  logic              CLK_I,
    input  logic              RST_I,
    input  logic              STEP_I,
    input  logic [2:0]        STATE_I,
    input  logic [1:0]        CTYPE_I,
    input  logic [ADDR_W-1:0] ADDR_I,
    input  logic [DATA_W-1:0] WDATA_I,
    output logic              READY_O,
    output logic [DATA_W-1:0] RDATA_O,
    output logic              RDATA_VLD_O,
    output logic              ERR_O,
    output logic              MEM_REQ_O,
    output logic              MEM_WE_O,
    output logic              MEM_IO_O,
    output logic [ADDR_W-1:0] MEM_ADDR_O,
    output logic [DATA_W-1:0] MEM_WDATA_O,
    input  logic              MEM_ACK_I,
    input  logic [DATA_W-1:0] MEM_RDATA_I
);

    bus_state_e        r_state;
    bus_state_e        w_nxt;

    logic              r_pend;
    logic [ADDR_W-1:0] r_sh_addr;
    logic [1:0]        r_sh_ctype;

    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic              r_io;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_ready;
    logic              r_rvld;
    logic              r_err;
    logic              r_req;

    logic              w_t1;
    logic              w_t3;
    logic              w_ack;
    logic              w_expire;
    logic              w_done;
    logic              w_load;
    logic [ADDR_W-1:0] w_ld_addr;
    logic [1:0]        w_ld_ctype;
    logic              w_set_pend;
    logic              w_clr_pend;
    logic              w_cap_rd;
    logic [DATA_W-1:0] w_rd_val;
    logic              w_cap_wd;
    logic              w_err;
    logic              w_clr_tmo;

    // STOP never qualifies as a T1 event, so no cycle can start while the
    // sequencer is stopped; an outstanding request still runs to completion.
    assign w_t1   = STEP_I & is_t1_code(STATE_I);
    assign w_t3   = STEP_I & (STATE_I == TS_T3);
    assign w_ack  = MEM_ACK_I & r_req;
    assign w_done = w_ack | w_expire;

    always_comb begin
        w_nxt      = r_state;
        w_load     = 1'b0;
        w_ld_addr  = ADDR_I;
        w_ld_ctype = CTYPE_I;
        w_set_pend = 1'b0;
        w_clr_pend = 1'b0;
        w_cap_rd   = 1'b0;
        w_rd_val   = MEM_RDATA_I;
        w_cap_wd   = 1'b0;
        w_err      = 1'b0;

        case (r_state)
            BUS_IDLE: begin
                if (w_t1) begin
                    w_load = 1'b1;
                    w_nxt  = cycle_entry_state(CTYPE_I);
                end
            end

            BUS_RD_REQ: begin
                // ACK in the expiry clock takes priority over the abort
                if (w_ack) begin
                    w_cap_rd = 1'b1;
                    w_nxt    = BUS_RD_DONE;
                end else if (w_expire) begin
                    w_cap_rd = 1'b1;
                    w_rd_val = '1;
                    w_err    = 1'b1;
                    w_nxt    = BUS_RD_DONE;
                end
            end

            BUS_RD_DONE: begin
                if (w_t3) begin
                    w_nxt = BUS_IDLE;
                end
            end

            BUS_WR_WAIT: begin
                if (w_t3) begin
                    w_cap_wd = 1'b1;
                    w_nxt    = BUS_WR_REQ;
                end
            end

            BUS_WR_REQ: begin
                if (w_done) begin
                    w_err = ~w_ack;
                    if (r_pend) begin
                        w_load     = 1'b1;
                        w_ld_addr  = r_sh_addr;
                        w_ld_ctype = r_sh_ctype;
                        w_clr_pend = 1'b1;
                        w_nxt      = cycle_entry_state(r_sh_ctype);
                    end else if (w_t1) begin
                        // T1 in the completing clock starts directly
                        w_load = 1'b1;
                        w_nxt  = cycle_entry_state(CTYPE_I);
                    end else begin
                        w_nxt = BUS_IDLE;
                    end
                end else if (w_t1 && !r_pend) begin
                    w_set_pend = 1'b1;
                end
            end

            default: begin
                w_nxt = BUS_IDLE;
            end
        endcase
    end

    // Any entry into a request state is a new transaction for the watchdog,
    // including a pending read chained directly after a write.
    assign w_clr_tmo = is_req_state(w_nxt) && (w_nxt != r_state);

    cpu_bus_wdog #(
        .TMO_CYC (TMO_CYC)
    ) u_wdog (
        .i_clk    (CLK_I),
        .i_rst    (RST_I),
        .i_clr    (w_clr_tmo),
        .i_run    (r_req),
        .o_expire (w_expire)
    );

    // Outputs are registered from the next-state decode so that no input
    // reaches an output combinationally.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            r_state <= BUS_IDLE;
            r_pend  <= 1'b0;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_io    <= 1'b0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_ready <= 1'b0;
            r_rvld  <= 1'b0;
            r_err   <= 1'b0;
            r_req   <= 1'b0;
        end else begin
            r_state <= w_nxt;
            if (w_set_pend) begin
                r_pend <= 1'b1;
            end else if (w_clr_pend) begin
                r_pend <= 1'b0;
            end
            if (w_load) begin
                r_addr <= w_ld_addr;
                r_we   <= ctype_is_write(w_ld_ctype);
                r_io   <= ctype_is_io(w_ld_ctype);
            end
            if (w_cap_wd) begin
                r_wdata <= WDATA_I;
            end
            if (w_cap_rd) begin
                r_rdata <= w_rd_val;
            end
            r_ready <= (w_nxt == BUS_RD_DONE) || (w_nxt == BUS_WR_WAIT);
            r_rvld  <= (w_nxt == BUS_RD_DONE);
            r_err   <= w_err;
            r_req   <= is_req_state(w_nxt);
        end
    end

    // Shadow slot for the one cycle allowed to queue behind a write
    always_ff @(posedge CLK_I) begin
        if (w_set_pend) begin
            r_sh_addr  <= ADDR_I;
            r_sh_ctype <= CTYPE_I;
        end
    end

    assign READY_O     = r_ready;
    assign RDATA_O     = r_rdata;
    assign RDATA_VLD_O = r_rvld;
    assign ERR_O       = r_err;
    assign MEM_REQ_O   = r_req;
    assign MEM_WE_O    = r_we;
    assign MEM_IO_O    = r_io;
    assign MEM_ADDR_O  = r_addr;
    assign MEM_WDATA_O = r_wdata;

endmodule

// File: tb/tb_cpu_bus_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cpu_bus_ctrl
// Bench for cpu_bus_ctrl. A sequencer task drives T-states, a memory device
// process answers requests with a scripted ACK delay, and monitors compare
// what the DUT presents against expectations queued when each cycle is
// issued. Expected read data comes from a flat memory model of both spaces.
// ---------------------------------------------------------------------------
module tb_cpu_bus_ctrl;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 8;
    localparam int TMO    = 8;

    logic              CLK_I = 1'b0;
    logic              RST_I = 1'b1;
    logic              STEP_I = 1'b0;
    logic [2:0]        STATE_I = 3'b101;
    logic [1:0]        CTYPE_I = 2'b00;
    logic [ADDR_W-1:0] ADDR_I = '0;
    logic [DATA_W-1:0] WDATA_I = '0;
    logic              MEM_ACK_I = 1'b0;
    logic [DATA_W-1:0] MEM_RDATA_I = '0;
    logic              READY_O;
    logic [DATA_W-1:0] RDATA_O;
    logic              RDATA_VLD_O;
    logic              ERR_O;
    logic              MEM_REQ_O;
    logic              MEM_WE_O;
    logic              MEM_IO_O;
    logic [ADDR_W-1:0] MEM_ADDR_O;
    logic [DATA_W-1:0] MEM_WDATA_O;

    cpu_bus_ctrl #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TMO_CYC (TMO)
    ) dut (
        .CLK_I       (CLK_I),
        .RST_I       (RST_I),
        .STEP_I      (STEP_I),
        .STATE_I     (STATE_I),
        .CTYPE_I     (CTYPE_I),
        .ADDR_I      (ADDR_I),
        .WDATA_I     (WDATA_I),
        .READY_O     (READY_O),
        .RDATA_O     (RDATA_O),
        .RDATA_VLD_O (RDATA_VLD_O),
        .ERR_O       (ERR_O),
        .MEM_REQ_O   (MEM_REQ_O),
        .MEM_WE_O    (MEM_WE_O),
        .MEM_IO_O    (MEM_IO_O),
        .MEM_ADDR_O  (MEM_ADDR_O),
        .MEM_WDATA_O (MEM_WDATA_O),
        .MEM_ACK_I   (MEM_ACK_I),
        .MEM_RDATA_I (MEM_RDATA_I)
    );

    always #5 CLK_I = ~CLK_I;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic              io;
        logic [DATA_W-1:0] wdata;
        int                d;      // ACK in d-th REQ clock; 0 = never (timeout)
    } req_t;

    req_t              req_q[$];
    logic [DATA_W-1:0] rd_q[$];
    logic [DATA_W-1:0] model_mem [logic [ADDR_W:0]];
    logic [DATA_W-1:0] dev_mem   [logic [ADDR_W:0]];
    req_t              cur;
    int                n_tests = 0;
    int                n_fail  = 0;
    int                exp_err = 0;
    int                seen_err = 0;
    bit                resp_en = 1'b1;
    logic              prev_vld = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic bound_fail(input string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s: wait bound expired (t=%0t)", nm, $time);
    endtask

    // Contents of never-written locations, shared by device and model
    function automatic logic [DATA_W-1:0] init_val(input logic [ADDR_W:0] k);
        return k[7:0] ^ k[ADDR_W-1 -: 8] ^ (k[ADDR_W] ? 8'h5A : 8'h00);
    endfunction

    function automatic logic [DATA_W-1:0] model_rd(input logic [ADDR_W:0] k);
        return model_mem.exists(k) ? model_mem[k] : init_val(k);
    endfunction

    function automatic logic [DATA_W-1:0] dev_rd(input logic [ADDR_W:0] k);
        return dev_mem.exists(k) ? dev_mem[k] : init_val(k);
    endfunction

    // Read-completion and error-pulse monitor
    always @(negedge CLK_I) begin
        if (ERR_O === 1'b1) seen_err++;
        if (RDATA_VLD_O === 1'b1 && prev_vld !== 1'b1) begin
            if (rd_q.size() == 0) begin
                bound_fail("rd_unexpected");
            end else begin
                chk("rdata", 32'(RDATA_O), 32'(rd_q.pop_front()));
            end
        end
        prev_vld = RDATA_VLD_O;
    end

    // Memory device: checks each new request against the issued cycle and
    // answers after the scripted delay.
    initial begin
        @(negedge CLK_I);
        forever begin
            if (resp_en && MEM_REQ_O === 1'b1) begin
                if (req_q.size() == 0) begin
                    bound_fail("req_unexpected");
                    @(negedge CLK_I);
                end else begin
                    cur = req_q.pop_front();
                    chk("mem_addr", 32'(MEM_ADDR_O), 32'(cur.addr));
                    chk("mem_we",   32'(MEM_WE_O),   32'(cur.we));
                    chk("mem_io",   32'(MEM_IO_O),   32'(cur.io));
                    if (cur.we) chk("mem_wdata", 32'(MEM_WDATA_O), 32'(cur.wdata));
                    if (cur.d == 0) begin
                        repeat (TMO - 1) @(negedge CLK_I);
                        chk("req_held_to_tmo", 32'(MEM_REQ_O), 32'd1);
                        @(negedge CLK_I);
                        chk("err_on_tmo", 32'(ERR_O), 32'd1);
                    end else begin
                        repeat (cur.d - 1) @(negedge CLK_I);
                        chk("req_held_to_ack", 32'(MEM_REQ_O), 32'd1);
                        MEM_ACK_I   = 1'b1;
                        MEM_RDATA_I = dev_rd({MEM_IO_O, MEM_ADDR_O});
                        if (MEM_WE_O) dev_mem[{MEM_IO_O, MEM_ADDR_O}] = MEM_WDATA_O;
                        @(negedge CLK_I);
                        MEM_ACK_I   = 1'b0;
                        MEM_RDATA_I = 8'($urandom);
                        chk("no_err_on_ack", 32'(ERR_O), 32'd0);
                    end
                end
            end else begin
                @(negedge CLK_I);
            end
        end
    end

    // One complete CPU cycle as the sequencer would run it.
    // lat: 1 = READY expected right after T1; 2 = READY expected low (pending)
    task automatic do_cycle(input logic [1:0] ct, input logic [ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] wd, input int d, input int lat);
        req_t              e;
        logic [ADDR_W:0]   key;
        logic [DATA_W-1:0] exp_rd;
        int                cnt;
        e.addr  = a;
        e.we    = (ct == 2'b11);
        e.io    = (ct == 2'b01);
        e.wdata = wd;
        e.d     = d;
        key     = {e.io, a};
        exp_rd  = '1;
        req_q.push_back(e);
        if (d == 0) exp_err++;
        if (e.we) begin
            if (d != 0) model_mem[key] = wd;
        end else begin
            if (d != 0) exp_rd = model_rd(key);
            rd_q.push_back(exp_rd);
        end
        STATE_I = ($urandom_range(0, 3) == 0) ? 3'b110 : 3'b010;
        STEP_I  = 1'b1;
        CTYPE_I = ct;
        ADDR_I  = a;
        @(negedge CLK_I);
        STEP_I  = 1'b0;
        CTYPE_I = 2'($urandom);
        ADDR_I  = ADDR_W'($urandom);
        if (lat == 1) chk("wr_ready_after_t1", 32'(READY_O), 32'd1);
        if (lat == 2) chk("pend_ready_low_t1", 32'(READY_O), 32'd0);
        STATE_I = 3'b100;
        STEP_I  = 1'b1;
        @(negedge CLK_I);
        STEP_I = 1'b0;
        if (lat == 2) chk("pend_ready_low_t2", 32'(READY_O), 32'd0);
        cnt = 0;
        while (READY_O !== 1'b1 && cnt < 200) begin
            STATE_I = 3'b000;
            STEP_I  = 1'($urandom_range(0, 1));
            @(negedge CLK_I);
            cnt++;
        end
        if (cnt >= 200) bound_fail("ready_wait");
        STATE_I = 3'b001;
        STEP_I  = 1'b1;
        WDATA_I = wd;
        @(negedge CLK_I);
        STEP_I  = 1'b0;
        WDATA_I = 8'($urandom);
        if (!e.we) begin
            chk("rdata_hold", 32'(RDATA_O), 32'(exp_rd));
            chk("vld_drop",   32'(RDATA_VLD_O), 32'd0);
        end
        STATE_I = 3'b111;
        STEP_I  = 1'b1;
        @(negedge CLK_I);
        STEP_I = 1'b0;
        repeat ($urandom_range(0, 3)) begin
            STATE_I = ($urandom_range(0, 1) == 0) ? 3'b101 : 3'b011;
            STEP_I  = 1'($urandom_range(0, 1));
            @(negedge CLK_I);
        end
        STEP_I = 1'b0;
    endtask

    task automatic drain();
        int cnt;
        cnt = 0;
        while ((req_q.size() != 0 || rd_q.size() != 0 || MEM_REQ_O !== 1'b0) && cnt < 200) begin
            @(negedge CLK_I);
            cnt++;
        end
        if (cnt >= 200) bound_fail("drain");
        repeat (2) @(negedge CLK_I);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [1:0]        ct;
        logic [ADDR_W-1:0] a;
        int                d;

        MEM_RDATA_I = 8'($urandom);
        repeat (3) @(negedge CLK_I);
        chk("rst_ready", 32'(READY_O),     32'd0);
        chk("rst_rvld",  32'(RDATA_VLD_O), 32'd0);
        chk("rst_err",   32'(ERR_O),       32'd0);
        chk("rst_req",   32'(MEM_REQ_O),   32'd0);
        chk("rst_we",    32'(MEM_WE_O),    32'd0);
        chk("rst_io",    32'(MEM_IO_O),    32'd0);
        chk("rst_addr",  32'(MEM_ADDR_O),  32'd0);
        chk("rst_wdata", 32'(MEM_WDATA_O), 32'd0);
        chk("rst_rdata", 32'(RDATA_O),     32'd0);
        RST_I = 1'b0;
        repeat (2) @(negedge CLK_I);

        // Directed cases
        model_mem[{1'b0, 14'h0123}] = 8'h3E;
        dev_mem[{1'b0, 14'h0123}]   = 8'h3E;
        do_cycle(2'b00, 14'h0123, 8'h00, 3, 0);     // fetch
        do_cycle(2'b11, 14'h2000, 8'h55, 5, 1);     // posted write
        drain();
        do_cycle(2'b10, 14'h2000, 8'h00, 2, 0);     // read back the write
        do_cycle(2'b11, 14'h2100, 8'hAA, 8, 0);     // long write ...
        do_cycle(2'b00, 14'h0124, 8'h00, 2, 2);     // ... with a fetch pending
        do_cycle(2'b10, 14'h0300, 8'h00, 0, 0);     // read timeout
        do_cycle(2'b10, 14'h2100, 8'h00, TMO, 0);   // ACK on the expiry clock
        do_cycle(2'b11, 14'h0400, 8'h77, 0, 0);     // write timeout ...
        do_cycle(2'b11, 14'h0401, 8'h88, 3, 2);     // ... with a write pending
        do_cycle(2'b10, 14'h0400, 8'h00, 1, 0);
        do_cycle(2'b10, 14'h0401, 8'h00, 1, 0);

        // Randomized cycles over a small address pool so reads hit writes
        for (int i = 0; i < 150; i++) begin
            ct = 2'($urandom);
            a  = ($urandom_range(0, 4) == 0) ? ADDR_W'($urandom) : ADDR_W'(14'h0100 + $urandom_range(0, 7));
            d  = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, TMO));
            do_cycle(ct, a, 8'($urandom), d, 0);
        end
        drain();

        // Reset in the middle of a read request
        resp_en = 1'b0;
        @(negedge CLK_I);
        STATE_I = 3'b010;
        STEP_I  = 1'b1;
        CTYPE_I = 2'b10;
        ADDR_I  = 14'h0777;
        @(negedge CLK_I);
        STEP_I  = 1'b0;
        STATE_I = 3'b100;
        @(negedge CLK_I);
        chk("req_before_rst", 32'(MEM_REQ_O), 32'd1);
        #2 RST_I = 1'b1;
        #1;
        chk("req_async_rst",   32'(MEM_REQ_O), 32'd0);
        chk("ready_async_rst", 32'(READY_O),   32'd0);
        @(negedge CLK_I);
        RST_I = 1'b0;
        @(negedge CLK_I);
        resp_en = 1'b1;
        do_cycle(2'b01, 14'h0042, 8'h00, 2, 0);     // IO read after reset
        do_cycle(2'b01, 14'h0042, 8'h00, 4, 0);
        drain();

        chk("err_pulse_count", 32'(seen_err), 32'(exp_err));
        chk("req_q_empty", 32'(req_q.size()), 32'd0);
        chk("rd_q_empty",  32'(rd_q.size()),  32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
